// File: rtl/divisor_pkg.sv
// rtl/divisor_pkg.sv - shared state encoding and default width for divisor_secuencial (DIVISOR_REDONDEO_EN adds REDONDEO)
package divisor_pkg;

   localparam int W_DEF = 24;

   typedef enum logic [1:0] {
      REPOSO  = 2'd0,
      DIVIDIR = 2'd1,
      FIN     = 2'd2
`ifdef DIVISOR_REDONDEO_EN
      , REDONDEO = 2'd3
`endif
   } estado_t;

endpackage

// File: rtl/divisor_secuencial_if.sv
// rtl/divisor_secuencial_if.sv - operand/result bundle between a requester and divisor_secuencial
interface divisor_secuencial_if
   import divisor_pkg::*;
#(
   parameter int W = W_DEF
);

   logic             Inicio;
   logic [2*W-1:0]   Dividendo;
   logic [W-1:0]     Divisor;
   logic [W-1:0]     Cociente;
   logic [W-1:0]     Residuo;
   logic             Ocupado;
   logic             Listo;
   logic             Desborde;
   logic             Div_cero;

   modport master (
      output Inicio, Dividendo, Divisor,
      input  Cociente, Residuo, Ocupado, Listo, Desborde, Div_cero
   );

   modport slave (
      input  Inicio, Dividendo, Divisor,
      output Cociente, Residuo, Ocupado, Listo, Desborde, Div_cero
   );

endinterface

// File: rtl/paso_division.sv
// rtl/paso_division.sv - one restoring-division step: shift in a dividend bit, compare, subtract
module paso_division #(
   parameter int W = 24
) (
   input  logic [W-1:0] resto_in,
   input  logic         bit_in,
   input  logic [W-1:0] divisor,
   output logic [W-1:0] resto_out,
   output logic         bit_q
);

   logic [W:0] parcial;
   logic [W:0] resta;

   // Trial subtraction on the W+1-bit partial remainder; keep it only if it does not go negative
   always_comb begin
      parcial   = {resto_in, bit_in};
      resta     = parcial - {1'b0, divisor};
      bit_q     = (parcial >= {1'b0, divisor});
      resto_out = bit_q ? resta[W-1:0] : parcial[W-1:0];
   end

endmodule

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - sequential 2W/W restoring divider, MSB first; DIVISOR_REDONDEO_EN adds round-half-up
module divisor_secuencial
   import divisor_pkg::*;
#(
   parameter int W = W_DEF
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   divisor_secuencial_if.slave  bus
);

   localparam int CW = $clog2(W + 1);

   estado_t        estado, estado_sig;
   logic [CW-1:0]  cuenta;
   logic [W-1:0]   resto;
   logic [W-1:0]   q_sr;       // low dividend half shifts out MSB first while quotient bits shift in
   logic [W-1:0]   divisor_r;
   logic           desb_r;
   logic           cero_r;
   logic [W-1:0]   resto_sig;
   logic           bit_q;
   logic           acepta;
   logic           cero_in;
   logic           desb_in;
   logic           ultimo;

   assign acepta  = (estado == REPOSO) && bus.Inicio;
   assign cero_in = (bus.Divisor == '0);
   assign desb_in = !cero_in && (bus.Dividendo[2*W-1:W] >= bus.Divisor);
   assign ultimo  = (cuenta == CW'(W - 1));

   paso_division #(.W(W)) u_paso (
      .resto_in  (resto),
      .bit_in    (q_sr[W-1]),
      .divisor   (divisor_r),
      .resto_out (resto_sig),
      .bit_q     (bit_q)
   );

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) estado <= REPOSO;
      else        estado <= estado_sig;
   end

   // Next state: degenerate operands skip straight to FIN
   always_comb begin
      estado_sig = estado;
      case (estado)
         REPOSO:  if (bus.Inicio) estado_sig = (cero_in || desb_in) ? FIN : DIVIDIR;
         DIVIDIR: if (ultimo) begin
`ifdef DIVISOR_REDONDEO_EN
                     estado_sig = REDONDEO;
`else
                     estado_sig = FIN;
`endif
                  end
`ifdef DIVISOR_REDONDEO_EN
         REDONDEO: estado_sig = FIN;
`endif
         FIN:     estado_sig = REPOSO;
         default: estado_sig = REPOSO;
      endcase
   end

   // Operand latch, iteration counter and working remainder/quotient
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         resto     <= '0;
         q_sr      <= '0;
         divisor_r <= '0;
         cuenta    <= '0;
         desb_r    <= 1'b0;
         cero_r    <= 1'b0;
      end else if (acepta) begin
         divisor_r <= bus.Divisor;
         cuenta    <= '0;
         cero_r    <= cero_in;
         desb_r    <= desb_in;
         if (cero_in || desb_in) begin
            resto <= '0;
            q_sr  <= '1;
         end else begin
            resto <= bus.Dividendo[2*W-1:W];
            q_sr  <= bus.Dividendo[W-1:0];
         end
      end else if (estado == DIVIDIR) begin
         resto  <= resto_sig;
         q_sr   <= {q_sr[W-2:0], bit_q};
         cuenta <= cuenta + 1'b1;
      end
`ifdef DIVISOR_REDONDEO_EN
      else if (estado == REDONDEO) begin
         if ({resto, 1'b0} >= {1'b0, divisor_r}) begin
            if (&q_sr) desb_r <= 1'b1;
            else       q_sr   <= q_sr + 1'b1;
         end
      end
`endif
   end

   // Result registers: published on leaving FIN, flags cleared on acceptance
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         bus.Cociente <= '0;
         bus.Residuo  <= '0;
         bus.Ocupado  <= 1'b0;
         bus.Listo    <= 1'b0;
         bus.Desborde <= 1'b0;
         bus.Div_cero <= 1'b0;
      end else begin
         bus.Listo   <= (estado == FIN);
         bus.Ocupado <= acepta || (bus.Ocupado && !bus.Listo);
         if (acepta) begin
            bus.Desborde <= 1'b0;
            bus.Div_cero <= 1'b0;
         end else if (estado == FIN) begin
            bus.Cociente <= q_sr;
            bus.Residuo  <= resto;
            bus.Desborde <= desb_r;
            bus.Div_cero <= cero_r;
         end
      end
   end

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - randomized and directed bench for divisor_secuencial against an arithmetic model
module tb_divisor_secuencial;

`ifdef DIVISOR_REDONDEO_EN
   localparam int LAT = 26;
`else
   localparam int LAT = 25;
`endif

   logic CLK = 1'b0;
   logic RST_N;

   divisor_secuencial_if #(.W(24)) bus ();

   divisor_secuencial #(.W(24)) dut (
      .CLK   (CLK),
      .RST_N (RST_N),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   bit chk_en = 1'b0;

   // model state: pending result and visible outputs
   bit          pend = 1'b0;
   int          fin_edge = 0;
   logic [23:0] p_q, p_r, m_q = '0, m_r = '0;
   bit          p_ovf, p_zero, m_ovf = 1'b0, m_zero = 1'b0, m_listo = 1'b0, m_ocup = 1'b0;

   task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic void model_div(input logic [47:0] dd, input logic [23:0] dv,
                                     output logic [23:0] q, output logic [23:0] r,
                                     output bit ovf, output bit zero, output int lat);
      longint unsigned qq, rr;
      ovf = 1'b0; zero = 1'b0;
      if (dv == 0) begin
         zero = 1'b1; q = 24'hFFFFFF; r = 0; lat = 1;
      end else begin
         qq = 64'(dd) / 64'(dv);
         rr = 64'(dd) % 64'(dv);
         if (qq > 64'hFFFFFF) begin
            ovf = 1'b1; q = 24'hFFFFFF; r = 0; lat = 1;
         end else begin
            q = qq[23:0]; r = rr[23:0]; lat = LAT;
`ifdef DIVISOR_REDONDEO_EN
            if (2 * rr >= 64'(dv)) begin
               if (qq == 64'hFFFFFF) ovf = 1'b1;
               else q = q + 24'd1;
            end
`endif
         end
      end
   endfunction

   // behavioural model: one accepted job at a time, result lands lat edges after acceptance
   initial begin
      int lat;
      forever begin
         @(posedge CLK or negedge RST_N);
         if (!RST_N) begin
            pend = 0; m_q = 0; m_r = 0; m_ovf = 0; m_zero = 0; m_listo = 0; m_ocup = 0;
         end else begin
            cyc++;
            m_listo = 0;
            if (!pend && bus.Inicio) begin
               model_div(bus.Dividendo, bus.Divisor, p_q, p_r, p_ovf, p_zero, lat);
               fin_edge = cyc + lat;
               pend = 1; m_ovf = 0; m_zero = 0;
            end else if (pend && cyc == fin_edge) begin
               m_q = p_q; m_r = p_r; m_ovf = p_ovf; m_zero = p_zero;
               m_listo = 1; pend = 0;
            end
            m_ocup = pend || m_listo;
         end
      end
   end

   // per-cycle comparison of every output against the model
   initial begin
      forever begin
         @(negedge CLK);
         if (chk_en) begin
            chk("Listo",    bus.Listo,    m_listo);
            chk("Ocupado",  bus.Ocupado,  m_ocup);
            chk("Cociente", bus.Cociente, m_q);
            chk("Residuo",  bus.Residuo,  m_r);
            chk("Desborde", bus.Desborde, m_ovf);
            chk("Div_cero", bus.Div_cero, m_zero);
         end
      end
   end

   task automatic start(input logic [47:0] dd, input logic [23:0] dv, output int acc);
      bus.Inicio = 1'b1; bus.Dividendo = dd; bus.Divisor = dv;
      @(negedge CLK);
      acc = cyc;
      bus.Inicio = 1'b0;
   endtask

   task automatic wait_listo(input int acc, output int lat);
      bit seen = 1'b0;
      lat = -1;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge CLK);
         if (bus.Listo) begin seen = 1'b1; lat = cyc - acc; end
      end
      chk("listo_timeout", seen, 1'b1);
   endtask

   initial begin
      int acc, lat;
      logic [63:0] tmp;
      logic [23:0] a, b, dv;
      RST_N = 1'b1;
      bus.Inicio = 1'b0; bus.Dividendo = '0; bus.Divisor = '0;
      #1 RST_N = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_Cociente", bus.Cociente, 0);
      chk("rst_Residuo",  bus.Residuo,  0);
      chk("rst_Ocupado",  bus.Ocupado,  0);
      chk("rst_Listo",    bus.Listo,    0);
      chk("rst_Desborde", bus.Desborde, 0);
      chk("rst_Div_cero", bus.Div_cero, 0);
      chk_en = 1'b1;
      RST_N = 1'b1;

      // basic division and latency
`ifdef DIVISOR_REDONDEO_EN
      start(48'd100, 24'd8, acc);
      wait_listo(acc, lat);
      chk("d100_lat", lat, 26);
      chk("d100_q", bus.Cociente, 13);
      chk("d100_r", bus.Residuo, 4);
`else
      start(48'd100, 24'd7, acc);
      wait_listo(acc, lat);
      chk("d100_lat", lat, 25);
      chk("d100_q", bus.Cociente, 14);
      chk("d100_r", bus.Residuo, 2);
`endif
      @(negedge CLK);

      // largest non-overflowing quotient
      start(48'hFFFFFE000001, 24'hFFFFFF, acc);
      wait_listo(acc, lat);
      chk("max_q", bus.Cociente, 24'hFFFFFF);
      chk("max_r", bus.Residuo, 0);
      chk("max_ovf", bus.Desborde, 0);
      @(negedge CLK);

      // divide by zero
      start(48'd12345, 24'd0, acc);
      wait_listo(acc, lat);
      chk("zero_lat", lat, 1);
      chk("zero_flag", bus.Div_cero, 1);
      chk("zero_q", bus.Cociente, 24'hFFFFFF);
      chk("zero_r", bus.Residuo, 0);
      @(negedge CLK);

      // overflow boundary
      start(48'h000001000000, 24'd1, acc);
      wait_listo(acc, lat);
      chk("ovf_lat", lat, 1);
      chk("ovf_flag", bus.Desborde, 1);
      chk("ovf_q", bus.Cociente, 24'hFFFFFF);
      repeat (2) @(negedge CLK);

      // reset in the middle of a division
      start(48'd5000, 24'd7, acc);
      repeat (9) @(negedge CLK);
      #2 RST_N = 1'b0;
      #1;
      chk("arst_Cociente", bus.Cociente, 0);
      chk("arst_Residuo",  bus.Residuo,  0);
      chk("arst_Ocupado",  bus.Ocupado,  0);
      chk("arst_Listo",    bus.Listo,    0);
      chk("arst_Desborde", bus.Desborde, 0);
      chk("arst_Div_cero", bus.Div_cero, 0);
      @(negedge CLK);
      RST_N = 1'b1;
      start(48'd777123, 24'd1000, acc);
      wait_listo(acc, lat);
      chk("post_rst_lat", lat, LAT);
      chk("post_rst_q", bus.Cociente, 777);
      chk("post_rst_r", bus.Residuo, 123);
      @(negedge CLK);

      // Inicio re-pulsed mid-division must be ignored
      start(48'd1000, 24'd3, acc);
      repeat (4) @(negedge CLK);
      bus.Inicio = 1'b1; bus.Dividendo = 48'd500; bus.Divisor = 24'd9;
      @(negedge CLK);
      bus.Inicio = 1'b0;
      wait_listo(acc, lat);
      chk("repulse_lat", lat, LAT);
      chk("repulse_q", bus.Cociente, 333);
      chk("repulse_r", bus.Residuo, 1);
      @(negedge CLK);

      // product regression: (a*b)/b == a, remainder zero
      for (int i = 0; i < 300; i++) begin
         a = 24'($urandom_range(1, 24'hFFFFFF));
         b = 24'($urandom_range(1, 24'hFFFFFF));
         if (i % 3 == 0) b = b >> $urandom_range(0, 22);
         if (b == 0) b = 24'd1;
         start(48'(a) * 48'(b), b, acc);
         wait_listo(acc, lat);
         chk("prod_q", bus.Cociente, a);
         chk("prod_r", bus.Residuo, 0);
      end

      // random operands with random Inicio timing, model-checked every cycle
      for (int i = 0; i < 3000; i++) begin
         tmp = {$urandom, $urandom};
         tmp = tmp >> $urandom_range(0, 47);
         dv  = 24'($urandom >> $urandom_range(8, 32));
         bus.Inicio    = ($urandom_range(0, 9) == 0);
         bus.Dividendo = tmp[47:0];
         bus.Divisor   = dv;
         @(negedge CLK);
      end
      bus.Inicio = 1'b0;
      repeat (LAT + 3) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/divisor_secuencial.md
DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

Interface
REQ-001 SHALL have parameter: W, default 24, operand width (dividend is 2*W bits, as produced by Multiplicador).
REQ-002 SHALL have port: CLK  input  1  single rising-edge clock.
REQ-003 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: Inicio  input  1  start request, sampled on CLK.
REQ-005 SHALL have port: Dividendo  input  2*W  unsigned dividend.
REQ-006 SHALL have port: Divisor  input  W  unsigned divisor.
REQ-007 SHALL have port: Cociente  output  W  quotient.
REQ-008 SHALL have port: Residuo  output  W  remainder.
REQ-009 SHALL have port: Ocupado  output  1  division in progress.
REQ-010 SHALL have port: Listo  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port: Desborde  output  1  quotient does not fit in W bits.
REQ-012 SHALL have port: Div_cero  output  1  divisor was zero.

Function
REQ-013 SHALL implement FSM states REPOSO, DIVIDIR, FIN; REPOSO -> DIVIDIR on Inicio=1 with valid operands; DIVIDIR -> FIN after W iterations; FIN -> REPOSO unconditionally after one cycle.
REQ-014 SHALL latch Dividendo and Divisor on the CLK edge where Inicio=1 in REPOSO; input changes afterwards SHALL not affect the result.
REQ-015 SHALL ignore Inicio while in DIVIDIR or FIN (no restart, no queueing).
REQ-016 SHALL perform restoring division, one quotient bit per cycle, MSB first, using a W+1-bit partial remainder.
REQ-017 SHALL assert Listo for exactly one cycle, W+1 cycles after the accepting edge (25 for W=24).
REQ-018 SHALL assert Ocupado from the cycle after the accepting edge until and including the Listo cycle.
REQ-019 SHALL, when latched Divisor=0, go directly to FIN: Div_cero=1, Desborde=0, Cociente=all ones, Residuo=0; Listo one cycle after acceptance.
REQ-020 SHALL, when Divisor!=0 and Dividendo[2W-1:W] >= Divisor, go directly to FIN: Desborde=1, Cociente=all ones (saturated), Residuo=0.
REQ-021 SHALL hold Cociente, Residuo, Desborde, Div_cero stable from Listo until the next accepted Inicio; flags SHALL clear on acceptance.
REQ-022 SHALL satisfy Dividendo = Cociente*Divisor + Residuo with Residuo < Divisor whenever Desborde=0 and Div_cero=0.

Reset
REQ-023 SHALL, on RST_N=0 at any time including mid-division, enter REPOSO and clear Cociente, Residuo, Ocupado, Listo, Desborde, Div_cero to 0 immediately (asynchronously).
REQ-024 SHALL accept Inicio on the first CLK edge after RST_N deasserts.

Configuration
REQ-025 SHALL, with macro DIVISOR_REDONDEO_EN defined, add one cycle after DIVIDIR: if 2*Residuo >= Divisor, Cociente increments (round half up); increment from all ones SHALL saturate and set Desborde; Residuo keeps the unrounded value; Listo latency becomes W+2.
REQ-026 SHALL, without DIVISOR_REDONDEO_EN, truncate the quotient and keep latency W+1.

Structure
REQ-027 SHALL place state encoding (REPOSO/DIVIDIR/FIN, plus REDONDEO when enabled) and the default width constant in a shared package divisor_pkg.
REQ-028 SHALL keep the one-bit restoring step (compare/subtract/shift) in sub-module paso_division; FSM, counter and output registers remain in divisor_secuencial.

Verification
REQ-029 SHALL cover: Dividendo=100, Divisor=7, Inicio pulse -> Cociente=14, Residuo=2, Listo exactly 25 cycles later (with DIVISOR_REDONDEO_EN: 100/8 -> Cociente=13, Residuo=4, 26 cycles).
REQ-030 SHALL cover: Dividendo=48'hFFFFFE000001, Divisor=24'hFFFFFF -> Cociente=24'hFFFFFF, Residuo=0, Desborde=0.
REQ-031 SHALL cover: Divisor=0 -> Div_cero=1, Cociente=24'hFFFFFF, Listo 1 cycle after acceptance; Dividendo=48'h000001000000, Divisor=1 -> Desborde=1.
REQ-032 SHALL cover: RST_N=0 at cycle 10 of a division -> all outputs 0 immediately; new Inicio after release -> correct result, no residue of the aborted operation.
REQ-033 SHALL cover: Inicio re-pulsed with new operands at cycle 5 of a division -> ignored, original result delivered at cycle 25.
REQ-034 SHALL cover: file-driven regression of 5000 pairs, Multiplicador product divided by its multiplicand operand -> Cociente equals the other operand, Residuo=0 (results logged to Cociente.txt).
